// File: rtl/reg_file_sb.sv
// reg_file_sb: parametrised 2R/1W register file with a per-register write
// scoreboard. Control reserves a destination when a multicycle result is
// launched, and the eventual writeback clears the reservation. Read ports
// report the busy state so decode can stall on RAW/WAW hazards.
//
// Ports:
//   CLK, RST_N          clock, asynchronous active-low reset
//   RA1/RD1/BUSY1       read port 1: address, data, outstanding-write flag
//   RA2/RD2/BUSY2       read port 2: address, data, outstanding-write flag
//   WE/WA3/WD3          write port: enable, address, data
//   RSV/RSV_A/RSV_ACK   reservation request, register to reserve, accept
//   PEND_CNT            registered count of pending registers
`timescale 1ns/1ps

module reg_file_sb #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 3,
    parameter int unsigned ZERO_REG = 0,
    parameter int unsigned BYPASS   = 1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [ADDR_W-1:0] RA1,
    input  logic [ADDR_W-1:0] RA2,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2,
    output logic              BUSY1,
    output logic              BUSY2,
    input  logic              WE,
    input  logic [ADDR_W-1:0] WA3,
    input  logic [DATA_W-1:0] WD3,
    input  logic              RSV,
    input  logic [ADDR_W-1:0] RSV_A,
    output logic              RSV_ACK,
    output logic [ADDR_W:0]   PEND_CNT
);

    localparam int unsigned NREGS = 2**ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [DATA_W-1:0] regs [NREGS];
    logic [NREGS-1:0]  pending_q;
    logic [NREGS-1:0]  pending_d;
    logic [CNT_W-1:0]  pend_cnt_q;

    logic wr_c;
    logic acc_c;
    logic acc_new_c;
    logic clr_c;

    // Effective write/reserve; R0 traffic is dropped when it is hardwired.
    always_comb begin
        wr_c  = WE  && !((ZERO_REG != 0) && (WA3 == '0));
        acc_c = RSV && !pending_q[RSV_A] && !((ZERO_REG != 0) && (RSV_A == '0));
    end

    // Count deltas: acc only fires on a clear bit, so it always adds one; a
    // completion subtracts one unless the same bit is re-reserved this edge.
    always_comb begin
        acc_new_c = acc_c;
        clr_c     = wr_c && pending_q[WA3] && !(acc_c && (RSV_A == WA3));
    end

    // Next pending vector; the reservation is applied last so it wins a tie.
    always_comb begin
        pending_d = pending_q;
        if (wr_c) begin
            pending_d[WA3] = 1'b0;
        end
        if (acc_c) begin
            pending_d[RSV_A] = 1'b1;
        end
    end

    // Register contents.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            regs <= '{default: '0};
        end else if (wr_c) begin
            regs[WA3] <= WD3;
        end
    end

    // Scoreboard state and pending population count.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pending_q  <= '0;
            pend_cnt_q <= '0;
        end else begin
            pending_q  <= pending_d;
            pend_cnt_q <= pend_cnt_q + CNT_W'(acc_new_c) - CNT_W'(clr_c);
        end
    end

    // Read port 1: R0 override beats bypass, bypass beats stored state.
    always_comb begin
        RD1   = regs[RA1];
        BUSY1 = pending_q[RA1];
        if ((BYPASS != 0) && wr_c && (WA3 == RA1)) begin
            RD1   = WD3;
            BUSY1 = 1'b0;
        end
        if ((ZERO_REG != 0) && (RA1 == '0)) begin
            RD1   = '0;
            BUSY1 = 1'b0;
        end
    end

    // Read port 2: identical priority to port 1.
    always_comb begin
        RD2   = regs[RA2];
        BUSY2 = pending_q[RA2];
        if ((BYPASS != 0) && wr_c && (WA3 == RA2)) begin
            RD2   = WD3;
            BUSY2 = 1'b0;
        end
        if ((ZERO_REG != 0) && (RA2 == '0)) begin
            RD2   = '0;
            BUSY2 = 1'b0;
        end
    end

    assign RSV_ACK  = acc_c;
    assign PEND_CNT = pend_cnt_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed bench for reg_file_sb. Two instances share all
// inputs: u_dut (ZERO_REG=1, BYPASS=1) and u_ref (ZERO_REG=0, BYPASS=0).
// Inputs change on the falling edge; combinational outputs are sampled 1ns
// later, registered effects are sampled after the following rising edge.
`timescale 1ns/1ps

module tb_reg_file_sb;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 3;

    logic              CLK = 1'b0;
    logic              RST_N;
    logic [ADDR_W-1:0] RA1, RA2, WA3, RSV_A;
    logic [DATA_W-1:0] WD3;
    logic              WE, RSV;

    logic [DATA_W-1:0] rd1_a, rd2_a, rd1_b, rd2_b;
    logic              busy1_a, busy2_a, busy1_b, busy2_b;
    logic              ack_a, ack_b;
    logic [ADDR_W:0]   cnt_a, cnt_b;

    int n_chk = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    reg_file_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1), .BYPASS(1)) u_dut (
        .CLK(CLK), .RST_N(RST_N),
        .RA1(RA1), .RA2(RA2), .RD1(rd1_a), .RD2(rd2_a),
        .BUSY1(busy1_a), .BUSY2(busy2_a),
        .WE(WE), .WA3(WA3), .WD3(WD3),
        .RSV(RSV), .RSV_A(RSV_A), .RSV_ACK(ack_a), .PEND_CNT(cnt_a)
    );

    reg_file_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(0), .BYPASS(0)) u_ref (
        .CLK(CLK), .RST_N(RST_N),
        .RA1(RA1), .RA2(RA2), .RD1(rd1_b), .RD2(rd2_b),
        .BUSY1(busy1_b), .BUSY2(busy2_b),
        .WE(WE), .WA3(WA3), .WD3(WD3),
        .RSV(RSV), .RSV_A(RSV_A), .RSV_ACK(ack_b), .PEND_CNT(cnt_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to the next falling edge and drop all request strobes.
    task automatic step_idle();
        @(negedge CLK);
        WE  = 1'b0;
        RSV = 1'b0;
    endtask

    initial begin
        RST_N = 1'b0;
        RA1 = '0; RA2 = '0; WA3 = '0; RSV_A = '0;
        WD3 = '0; WE = 1'b0; RSV = 1'b0;
        repeat (2) @(posedge CLK);

        // Reset state on every register via both ports.
        @(negedge CLK);
        RST_N = 1'b1;
        for (int i = 0; i < 8; i++) begin
            RA1 = ADDR_W'(i);
            RA2 = ADDR_W'(7 - i);
            #1;
            chk($sformatf("rst_rd1_r%0d", i), 32'(rd1_a), 32'h0);
            chk($sformatf("rst_rd2_r%0d", 7 - i), 32'(rd2_a), 32'h0);
            chk($sformatf("rst_busy_r%0d", i), 32'({busy1_a, busy2_a, busy1_b, busy2_b}), 32'h0);
            @(negedge CLK);
        end
        chk("rst_cnt", 32'({cnt_a, cnt_b}), 32'h0);

        // Write 5 with same-cycle read on port 2.
        WE = 1'b1; WA3 = 3'd5; WD3 = 16'hBEEF; RA1 = 3'd5; RA2 = 3'd5;
        #1;
        chk("byp_rd2", 32'(rd2_a), 32'hBEEF);
        chk("nobyp_rd2_old", 32'(rd2_b), 32'h0);
        step_idle();
        #1;
        chk("wr_rd1", 32'(rd1_a), 32'hBEEF);
        chk("wr_rd1_ref", 32'(rd1_b), 32'hBEEF);

        // Reserve 3, retry (WAW refused), then complete it.
        step_idle();
        RSV = 1'b1; RSV_A = 3'd3; RA1 = 3'd3;
        #1;
        chk("rsv3_ack", 32'({ack_a, ack_b}), 32'h3);
        step_idle();
        RSV = 1'b1; RSV_A = 3'd3;
        #1;
        chk("rsv3_busy", 32'({busy1_a, busy1_b}), 32'h3);
        chk("rsv3_cnt", 32'(cnt_a), 32'd1);
        chk("rsv3_waw_ack", 32'({ack_a, ack_b}), 32'h0);
        step_idle();
        WE = 1'b1; WA3 = 3'd3; WD3 = 16'h1234;
        #1;
        chk("rsv3_cnt_hold", 32'({cnt_a, cnt_b}), 32'h11);
        chk("cmp3_byp_busy", 32'(busy1_a), 32'h0);
        chk("cmp3_raw_busy", 32'(busy1_b), 32'h1);
        chk("cmp3_byp_rd", 32'(rd1_a), 32'h1234);
        step_idle();
        #1;
        chk("cmp3_busy", 32'({busy1_a, busy1_b}), 32'h0);
        chk("cmp3_cnt", 32'({cnt_a, cnt_b}), 32'h00);
        chk("cmp3_rd", 32'(rd1_b), 32'h1234);

        // Simultaneous write+reserve to 4 while 4 is pending.
        RSV = 1'b1; RSV_A = 3'd4; RA1 = 3'd4;
        step_idle();
        WE = 1'b1; WA3 = 3'd4; WD3 = 16'h4444; RSV = 1'b1; RSV_A = 3'd4;
        #1;
        chk("sim_pend_ack", 32'({ack_a, ack_b}), 32'h0);
        chk("sim_pend_cnt_pre", 32'(cnt_a), 32'd1);
        step_idle();
        #1;
        chk("sim_pend_rd", 32'({rd1_a, rd1_b}), 32'h4444_4444);
        chk("sim_pend_busy", 32'({busy1_a, busy1_b}), 32'h0);
        chk("sim_pend_cnt", 32'({cnt_a, cnt_b}), 32'h00);

        // Simultaneous write+reserve to 4 while 4 is free: reservation wins.
        WE = 1'b1; WA3 = 3'd4; WD3 = 16'h5555; RSV = 1'b1; RSV_A = 3'd4;
        #1;
        chk("sim_free_ack", 32'({ack_a, ack_b}), 32'h3);
        step_idle();
        #1;
        chk("sim_free_busy", 32'({busy1_a, busy1_b}), 32'h3);
        chk("sim_free_cnt", 32'({cnt_a, cnt_b}), 32'h11);
        chk("sim_free_rd", 32'(rd1_b), 32'h5555);

        // R0 write and reserve: dropped on u_dut, honoured on u_ref.
        WE = 1'b1; WA3 = 3'd0; WD3 = 16'hFFFF; RA1 = 3'd0;
        #1;
        chk("z_rd_wrcycle", 32'(rd1_a), 32'h0);
        step_idle();
        RSV = 1'b1; RSV_A = 3'd0;
        #1;
        chk("z_rd", 32'(rd1_a), 32'h0);
        chk("z_rd_ref", 32'(rd1_b), 32'hFFFF);
        chk("z_ack", 32'(ack_a), 32'h0);
        chk("z_ack_ref", 32'(ack_b), 32'h1);
        step_idle();
        #1;
        chk("z_cnt", 32'({cnt_a, cnt_b}), 32'h12);

        // Build up state, then pulse reset between clock edges.
        RSV = 1'b1; RSV_A = 3'd1;
        step_idle();
        RSV = 1'b1; RSV_A = 3'd2;
        step_idle();
        RSV = 1'b1; RSV_A = 3'd6; WE = 1'b1; WA3 = 3'd7; WD3 = 16'h00AA;
        step_idle();
        RA1 = 3'd7; RA2 = 3'd1;
        #1;
        chk("pre_rst_rd7", 32'(rd1_a), 32'h00AA);
        chk("pre_rst_cnt", 32'({cnt_a, cnt_b}), 32'h45);
        chk("pre_rst_busy", 32'({busy2_a, busy2_b}), 32'h3);
        #1;
        RST_N = 1'b0;
        #1;
        chk("arst_cnt", 32'({cnt_a, cnt_b}), 32'h00);
        chk("arst_rd7", 32'({rd1_a, rd1_b}), 32'h0);
        chk("arst_busy", 32'({busy2_a, busy2_b}), 32'h0);

        // Writes and reserves are ignored while reset is held.
        @(negedge CLK);
        WE = 1'b1; WA3 = 3'd7; WD3 = 16'h1111; RSV = 1'b1; RSV_A = 3'd5;
        step_idle();
        RA2 = 3'd5;
        #1;
        chk("rst_hold_rd7", 32'({rd1_a, rd1_b}), 32'h0);
        chk("rst_hold_busy5", 32'({busy2_a, busy2_b}), 32'h0);
        RST_N = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step_idle();
            RA1 = ADDR_W'(i);
            #1;
            chk($sformatf("post_rst_busy_r%0d", i), 32'({busy1_a, busy1_b}), 32'h0);
        end
        chk("post_rst_cnt", 32'({cnt_a, cnt_b}), 32'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
